// File: rtl/jtag_tap_master.sv
// Bit-banging IEEE 1149.1 TAP initiator: loads one instruction, then scans one data register
// of programmable length, returning the captured TDO bits in dr_out.
module jtag_tap_master #(
    parameter int IR_LEN     = 8,
    parameter int MAX_DR_LEN = 32,
    parameter int TCK_DIV    = 2
) (
    input  logic                            CLK,
    input  logic                            RSTN,
    input  logic                            start,
    input  logic [IR_LEN-1:0]               ir_value,
    input  logic [$clog2(MAX_DR_LEN+1)-1:0] dr_len,
    input  logic [MAX_DR_LEN-1:0]           dr_in,
    output logic                            busy,
    output logic                            done,
    output logic [MAX_DR_LEN-1:0]           dr_out,
    output logic                            TCK,
    output logic                            TMS,
    output logic                            TDI,
    input  logic                            TDO
);
    localparam int LEN_W   = $clog2(MAX_DR_LEN + 1);
    localparam int CNT_MAX = (IR_LEN > MAX_DR_LEN) ? ((IR_LEN > 6) ? IR_LEN : 6)
                                                   : ((MAX_DR_LEN > 6) ? MAX_DR_LEN : 6);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIV_W   = (TCK_DIV > 2) ? $clog2(TCK_DIV) : 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(5);
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] IR_LAST  = CNT_W'(IR_LEN - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        RESET_SEQ,
        HDR_IR,
        SHIFT_IR,
        HDR_DR,
        SHIFT_DR,
        TRAILER
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_q, bit_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  phase_q, phase_d;
    logic                  tck_q, tck_d;
    logic                  tms_q, tms_d;
    logic                  tdi_q, tdi_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [MAX_DR_LEN-1:0] dr_out_q, dr_out_d;
    logic [MAX_DR_LEN-1:0] dr_cap_q, dr_cap_d;
    logic [IR_LEN-1:0]     ir_q, ir_d;
    logic [LEN_W-1:0]      dr_len_q, dr_len_d;
    logic [MAX_DR_LEN-1:0] dr_in_q, dr_in_d;

    logic                  len_ok;
    logic                  new_period;
    logic                  dr_last;
    logic [IR_LEN-1:0]     ir_bits;
    logic [MAX_DR_LEN-1:0] dr_bits;

    // The reset state doubles as the first low phase of the Test-Logic-Reset sequence.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= RESET_SEQ;
            bit_q    <= '0;
            div_q    <= '0;
            phase_q  <= 1'b0;
            tck_q    <= 1'b0;
            tms_q    <= 1'b1;
            tdi_q    <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            dr_out_q <= '0;
            dr_cap_q <= '0;
            ir_q     <= '0;
            dr_len_q <= '0;
            dr_in_q  <= '0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            phase_q  <= phase_d;
            tck_q    <= tck_d;
            tms_q    <= tms_d;
            tdi_q    <= tdi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dr_out_q <= dr_out_d;
            dr_cap_q <= dr_cap_d;
            ir_q     <= ir_d;
            dr_len_q <= dr_len_d;
            dr_in_q  <= dr_in_d;
        end
    end

    assign len_ok  = (dr_len != '0) && (dr_len <= LEN_W'(MAX_DR_LEN));
    assign dr_last = (bit_q == CNT_W'(dr_len_q - 1'b1));

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        div_d      = div_q;
        phase_d    = phase_q;
        tck_d      = tck_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dr_out_d   = dr_out_q;
        dr_cap_d   = dr_cap_q;
        ir_d       = ir_q;
        dr_len_d   = dr_len_q;
        dr_in_d    = dr_in_q;
        new_period = 1'b0;
        ir_bits    = '0;
        dr_bits    = '0;

        if (state_q == IDLE) begin
            if (start && len_ok) begin
                state_d    = HDR_IR;
                bit_d      = '0;
                div_d      = '0;
                phase_d    = 1'b0;
                tck_d      = 1'b0;
                busy_d     = 1'b1;
                dr_cap_d   = '0;
                ir_d       = ir_value;
                dr_len_d   = dr_len;
                dr_in_d    = dr_in;
                new_period = 1'b1;
            end
        end else if (div_q != DIV_LAST) begin
            div_d = div_q + 1'b1;
        end else begin
            div_d = '0;
            if (!phase_q) begin
                // Rising TCK: TDO is stable here because the TAP drives it on the falling edge.
                phase_d = 1'b1;
                tck_d   = 1'b1;
                if (state_q == SHIFT_DR) begin
                    dr_cap_d = dr_cap_q | (MAX_DR_LEN'(TDO) << bit_q);
                end
            end else begin
                phase_d    = 1'b0;
                tck_d      = 1'b0;
                new_period = 1'b1;
                bit_d      = bit_q + 1'b1;
                case (state_q)
                    RESET_SEQ: if (bit_q == RST_LAST) begin
                        state_d = IDLE;
                        bit_d   = '0;
                        busy_d  = 1'b0;
                    end
                    HDR_IR: if (bit_q == HDR_LAST) begin
                        state_d = SHIFT_IR;
                        bit_d   = '0;
                    end
                    SHIFT_IR: if (bit_q == IR_LAST) begin
                        state_d = HDR_DR;
                        bit_d   = '0;
                    end
                    HDR_DR: if (bit_q == HDR_LAST) begin
                        state_d = SHIFT_DR;
                        bit_d   = '0;
                    end
                    SHIFT_DR: if (dr_last) begin
                        state_d = TRAILER;
                        bit_d   = '0;
                    end
                    TRAILER: if (bit_q == CNT_W'(1)) begin
                        state_d  = IDLE;
                        bit_d    = '0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        dr_out_d = dr_cap_q;
                    end
                    default: ;
                endcase
            end
        end

        // TMS/TDI only move at the start of a low phase, from the period about to begin.
        if (new_period) begin
            tms_d = 1'b0;
            tdi_d = 1'b0;
            case (state_d)
                RESET_SEQ:      tms_d = (bit_d < RST_LAST);
                HDR_IR, HDR_DR: tms_d = (bit_d < CNT_W'(2));
                SHIFT_IR: begin
                    tms_d   = (bit_d == IR_LAST);
                    ir_bits = ir_d >> bit_d;
                    tdi_d   = ir_bits[0];
                end
                SHIFT_DR: begin
                    tms_d   = (bit_d == CNT_W'(dr_len_d - 1'b1));
                    dr_bits = dr_in_d >> bit_d;
                    tdi_d   = dr_bits[0];
                end
                TRAILER:        tms_d = (bit_d == '0);
                default: ;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign dr_out = dr_out_q;
    assign TCK    = tck_q;
    assign TMS    = tms_q;
    assign TDI    = tdi_q;

endmodule

// File: tb/tb_jtag_tap_master.sv
// Testbench for jtag_tap_master: drives transactions into a behavioural IEEE 1149.1 TAP model
// and checks TCK/TMS/TDI traces, timing and captured/updated register contents.
module tb_jtag_tap_master;
    localparam int IR_LEN     = 8;
    localparam int MAX_DR_LEN = 32;
    localparam int TCK_DIV    = 2;
    localparam int LEN_W      = $clog2(MAX_DR_LEN + 1);

    logic                  CLK      = 1'b0;
    logic                  RSTN     = 1'b1;
    logic                  start    = 1'b0;
    logic [IR_LEN-1:0]     ir_value = '0;
    logic [LEN_W-1:0]      dr_len   = '0;
    logic [MAX_DR_LEN-1:0] dr_in    = '0;
    logic                  busy, done, TCK, TMS, TDI;
    logic [MAX_DR_LEN-1:0] dr_out;
    logic                  TDO      = 1'b0;

    int checks = 0;
    int errors = 0;

    jtag_tap_master #(
        .IR_LEN(IR_LEN),
        .MAX_DR_LEN(MAX_DR_LEN),
        .TCK_DIV(TCK_DIV)
    ) dut (
        .CLK(CLK),
        .RSTN(RSTN),
        .start(start),
        .ir_value(ir_value),
        .dr_len(dr_len),
        .dr_in(dr_in),
        .busy(busy),
        .done(done),
        .dr_out(dr_out),
        .TCK(TCK),
        .TMS(TMS),
        .TDI(TDI),
        .TDO(TDO)
    );

    always #5 CLK = ~CLK;

    // Behavioural TAP with one user data register whose parallel capture/update ports are m_cap/m_upd.
    typedef enum int {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_t;

    tap_t              tap_st = SH_DR;
    logic [63:0]       m_cap  = '0;
    logic [63:0]       m_upd  = '0;
    logic [63:0]       dsh    = '0;
    int                m_len  = 9;
    logic [IR_LEN-1:0] ish    = '0;
    logic [IR_LEN-1:0] m_ir   = '0;
    bit                rise_tms[$];
    bit                rise_tdi[$];
    int                done_cnt = 0;

    int base      = 0;
    int done_base = 0;

    function automatic logic [63:0] lenMask(input int n);
        if (n >= 64) return '1;
        return (64'd1 << n) - 64'd1;
    endfunction

    always @(posedge TCK) begin
        rise_tms.push_back(TMS);
        rise_tdi.push_back(TDI);
        case (tap_st)
            CAP_DR: dsh = m_cap;
            SH_DR: begin
                dsh = dsh >> 1;
                dsh[m_len-1] = TDI;
            end
            UPD_DR: m_upd = dsh & lenMask(m_len);
            CAP_IR: ish = IR_LEN'(1);
            SH_IR:  ish = {TDI, ish[IR_LEN-1:1]};
            UPD_IR: m_ir = ish;
            default: ;
        endcase
        case (tap_st)
            TLR:    tap_st = TMS ? TLR    : RTI;
            RTI:    tap_st = TMS ? SEL_DR : RTI;
            SEL_DR: tap_st = TMS ? SEL_IR : CAP_DR;
            CAP_DR: tap_st = TMS ? EX1_DR : SH_DR;
            SH_DR:  tap_st = TMS ? EX1_DR : SH_DR;
            EX1_DR: tap_st = TMS ? UPD_DR : PAU_DR;
            PAU_DR: tap_st = TMS ? EX2_DR : PAU_DR;
            EX2_DR: tap_st = TMS ? UPD_DR : SH_DR;
            UPD_DR: tap_st = TMS ? SEL_DR : RTI;
            SEL_IR: tap_st = TMS ? TLR    : CAP_IR;
            CAP_IR: tap_st = TMS ? EX1_IR : SH_IR;
            SH_IR:  tap_st = TMS ? EX1_IR : SH_IR;
            EX1_IR: tap_st = TMS ? UPD_IR : PAU_IR;
            PAU_IR: tap_st = TMS ? EX2_IR : PAU_IR;
            EX2_IR: tap_st = TMS ? UPD_IR : SH_IR;
            UPD_IR: tap_st = TMS ? SEL_DR : RTI;
            default: tap_st = TLR;
        endcase
    end

    always @(negedge TCK) begin
        if (tap_st == SH_DR)      TDO = dsh[0];
        else if (tap_st == SH_IR) TDO = ish[0];
        else                      TDO = 1'b0;
    end

    always @(posedge CLK) begin
        if (done) done_cnt++;
    end

    // Expected TMS on each TCK rise, straight from the state list (bit i = i-th rise).
    function automatic logic [63:0] expTms(input int len);
        bit q[$];
        logic [63:0] v;
        v = '0;
        q.push_back(1); q.push_back(1); q.push_back(0); q.push_back(0);
        for (int k = 0; k < IR_LEN; k++) q.push_back(k == IR_LEN - 1);
        q.push_back(1); q.push_back(1); q.push_back(0); q.push_back(0);
        for (int k = 0; k < len; k++) q.push_back(k == len - 1);
        q.push_back(1); q.push_back(0);
        for (int i = 0; i < q.size() && i < 64; i++) v[i] = q[i];
        return v;
    endfunction

    function automatic logic [63:0] packRises(input bit use_tdi, input int first, input int count);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < count && i < 64; i++) begin
            if (first + i < rise_tms.size()) v[i] = use_tdi ? rise_tdi[first + i] : rise_tms[first + i];
        end
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling CLK edge; start is held for exactly one rising edge.
    task automatic applyStimulus(input logic [IR_LEN-1:0] ir, input logic [LEN_W-1:0] len,
                                 input logic [MAX_DR_LEN-1:0] din);
        base      = rise_tms.size();
        done_base = done_cnt;
        ir_value  = ir;
        dr_len    = len;
        dr_in     = din;
        start     = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start     = 1'b0;
    endtask

    task automatic waitDone(input int nper, input bit poke, output int cycles);
        cycles = 0;
        while (!done && cycles < 4 * TCK_DIV * nper + 100) begin
            if (poke && cycles < 2 * TCK_DIV * nper - 8) begin
                start    = 1'($urandom_range(0, 1));
                ir_value = IR_LEN'($urandom);
                dr_len   = LEN_W'($urandom);
                dr_in    = MAX_DR_LEN'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge CLK);
            cycles++;
        end
        start = 1'b0;
        checkOutput("done_seen", done, 1);
    endtask

    task automatic runTransaction(input logic [IR_LEN-1:0] ir, input int len,
                                  input logic [MAX_DR_LEN-1:0] din, input logic [63:0] cap,
                                  input bit poke);
        int cycles;
        int nper;
        logic [63:0] mask;
        nper  = IR_LEN + len + 10;
        mask  = lenMask(len);
        m_cap = cap;
        m_len = len;
        applyStimulus(ir, LEN_W'(len), din);
        checkOutput("busy_after_accept", busy, 1);
        waitDone(nper, poke, cycles);
        checkOutput("txn_cycles", cycles, 2 * TCK_DIV * nper);
        checkOutput("tck_rises", rise_tms.size() - base, nper);
        checkOutput("tms_trace", packRises(0, base, nper), expTms(len));
        checkOutput("ir_tdi", packRises(1, base + 4, IR_LEN), ir);
        checkOutput("dr_tdi", packRises(1, base + IR_LEN + 8, len), din & mask);
        checkOutput("busy_in_done", busy, 0);
        checkOutput("tck_low_done", TCK, 0);
        checkOutput("dr_out", dr_out, cap & mask);
        checkOutput("tap_dr_update", m_upd, din & mask);
        checkOutput("tap_ir", m_ir, ir);
        checkOutput("tap_rti", tap_st == RTI, 1);
    endtask

    task automatic releaseReset();
        int cycles;
        base = rise_tms.size();
        RSTN = 1'b1;
        cycles = 0;
        while (busy && cycles < 400) begin
            @(negedge CLK);
            cycles++;
        end
        checkOutput("reset_seq_ends", busy, 0);
        checkOutput("reset_rises", rise_tms.size() - base, 6);
        checkOutput("reset_tms", packRises(0, base, 6), 64'h1F);
        checkOutput("reset_tap_rti", tap_st == RTI, 1);
        checkOutput("reset_dr_out", dr_out, 0);
    endtask

    initial begin
        #1 RSTN = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("rst_tck", TCK, 0);
        checkOutput("rst_tms", TMS, 1);
        checkOutput("rst_tdi", TDI, 0);
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_dr_out", dr_out, 0);
        done_base = done_cnt;
        releaseReset();
        checkOutput("reset_no_done", done_cnt - done_base, 0);
        @(negedge CLK);
        checkOutput("idle_tms", TMS, 0);
        checkOutput("idle_tck", TCK, 0);

        $display("[TB] ER2 scan");
        runTransaction(8'h38, 9, 32'h0A5, 64'h13C, 0);
        @(negedge CLK);
        checkOutput("done_one_cycle", done, 0);
        checkOutput("done_count", done_cnt - done_base, 1);

        $display("[TB] illegal dr_len while idle");
        for (int t = 0; t < 2; t++) begin
            base     = rise_tms.size();
            ir_value = IR_LEN'($urandom);
            dr_in    = MAX_DR_LEN'($urandom);
            dr_len   = (t == 0) ? LEN_W'(0) : LEN_W'(MAX_DR_LEN + 1);
            start    = 1'b1;
            repeat (6) @(negedge CLK);
            start    = 1'b0;
            checkOutput("illegal_busy", busy, 0);
            checkOutput("illegal_tck_rises", rise_tms.size() - base, 0);
            checkOutput("illegal_dr_out", dr_out, 64'h13C);
        end

        $display("[TB] starts while busy");
        runTransaction(IR_LEN'($urandom), $urandom_range(1, MAX_DR_LEN),
                       MAX_DR_LEN'($urandom), 64'($urandom), 1);

        $display("[TB] random transactions");
        for (int t = 0; t < 5; t++) begin
            @(negedge CLK);
            runTransaction(IR_LEN'($urandom), $urandom_range(1, MAX_DR_LEN),
                           MAX_DR_LEN'($urandom), 64'($urandom), 0);
        end

        $display("[TB] length extremes back-to-back");
        @(negedge CLK);
        runTransaction(IR_LEN'($urandom), 1, MAX_DR_LEN'($urandom), 64'($urandom), 0);
        runTransaction(IR_LEN'($urandom), MAX_DR_LEN, MAX_DR_LEN'($urandom), 64'($urandom) | 64'd1, 0);
        runTransaction(IR_LEN'($urandom), 1, MAX_DR_LEN'($urandom), 64'd1, 0);

        $display("[TB] reset mid-scan");
        @(negedge CLK);
        m_cap = 64'($urandom);
        m_len = 20;
        applyStimulus(IR_LEN'($urandom), LEN_W'(20), MAX_DR_LEN'($urandom));
        for (int c = 0; c < 400 && (rise_tms.size() - base) < IR_LEN + 13; c++) @(negedge CLK);
        checkOutput("midscan_reached", (rise_tms.size() - base) >= IR_LEN + 13, 1);
        #2 RSTN = 1'b0;
        #1;
        checkOutput("abort_tck", TCK, 0);
        checkOutput("abort_tms", TMS, 1);
        checkOutput("abort_dr_out", dr_out, 0);
        checkOutput("abort_busy", busy, 1);
        repeat (2) @(negedge CLK);
        releaseReset();
        checkOutput("abort_no_done", done_cnt - done_base, 0);

        @(negedge CLK);
        runTransaction(IR_LEN'($urandom), $urandom_range(1, MAX_DR_LEN),
                       MAX_DR_LEN'($urandom), 64'($urandom), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
